// File: rtl/bcd_add_sequencer_if.sv
// Operand/result bundle between the requester (master) and the BCD add sequencer (slave).
// start/op_a/op_b flow toward the sequencer; status and the registered sum flow back.
interface bcd_add_sequencer_if #(
  parameter int NUM_PAIRS = 4
);
  logic                   start;
  logic [8*NUM_PAIRS-1:0] op_a;
  logic [8*NUM_PAIRS-1:0] op_b;
  logic                   busy;
  logic                   done;
  logic [8*NUM_PAIRS-1:0] result;
  logic                   overflow;
  logic                   invalid;

  modport master (
    output start, op_a, op_b,
    input  busy, done, result, overflow, invalid
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, result, overflow, invalid
  );
endinterface

// File: rtl/bcd_add_sequencer.sv
// Multi-digit packed-BCD adder processing one two-digit pair per cycle, LS pair first.
// Done pulses NUM_PAIRS+1 cycles after start (1 cycle for bad digits); start is ignored while not idle.
module bcd_add2 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       carry
);
  logic [4:0] lo_raw;
  logic [4:0] hi_raw;
  logic       lo_c;

  // Adding 6 modulo 16 folds a decimal digit sum of 10..19 back into 0..9.
  assign lo_raw   = {1'b0, a[3:0]} + {1'b0, b[3:0]};
  assign lo_c     = (lo_raw > 5'd9);
  assign sum[3:0] = lo_c ? (lo_raw[3:0] + 4'd6) : lo_raw[3:0];
  assign hi_raw   = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, lo_c};
  assign carry    = (hi_raw > 5'd9);
  assign sum[7:4] = carry ? (hi_raw[3:0] + 4'd6) : hi_raw[3:0];
endmodule

module bcd_add_sequencer #(
  parameter int NUM_PAIRS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_add_sequencer_if.slave bus
);
  localparam int W     = 8 * NUM_PAIRS;
  localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [IDX_W+2:0] base;
  logic [7:0]       pair_a;
  logic [7:0]       pair_b;
  logic [7:0]       s1;
  logic [7:0]       s2;
  logic             c1;
  logic             c2;
  logic             operand_bad;
  logic             last_pair;

  assign base      = {idx, 3'b000};
  assign pair_a    = a_reg[base +: 8];
  assign pair_b    = b_reg[base +: 8];
  assign last_pair = (idx == IDX_W'(NUM_PAIRS - 1));

  bcd_add2 u_add_ab  (.a(pair_a), .b(pair_b),              .sum(s1), .carry(c1));
  bcd_add2 u_add_cin (.a(s1),     .b({7'b0000000, carry_reg}), .sum(s2), .carry(c2));

  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < 2 * NUM_PAIRS; i++) begin
      if ((bus.op_a[4*i +: 4] > 4'd9) || (bus.op_b[4*i +: 4] > 4'd9)) begin
        operand_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      idx          <= '0;
      carry_reg    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.overflow <= 1'b0;
      bus.invalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_reg        <= bus.op_a;
            b_reg        <= bus.op_b;
            idx          <= '0;
            carry_reg    <= 1'b0;
            bus.result   <= '0;
            bus.overflow <= 1'b0;
            if (operand_bad) begin
              bus.invalid <= 1'b1;
              bus.done    <= 1'b1;
              state       <= DONE;
            end else begin
              bus.invalid <= 1'b0;
              bus.busy    <= 1'b1;
              state       <= ADD;
            end
          end
        end
        ADD: begin
          bus.result[base +: 8] <= s2;
          carry_reg             <= c1 | c2;
          idx                   <= idx + 1'b1;
          if (last_pair) begin
            bus.overflow <= c1 | c2;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Directed bench for bcd_add_sequencer (NUM_PAIRS=4): hand-computed sums, latency, invalid digits, start handling, mid-op reset.
module tb_bcd_add_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd_add_sequencer_if #(.NUM_PAIRS(4)) bus ();

  bcd_add_sequencer #(.NUM_PAIRS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands with start high and returns just after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_done(input logic hold, input logic disturb,
                           output int lat, output logic busy_seen, output logic overlap);
    lat       = 99;
    busy_seen = 1'b0;
    overlap   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!hold && k == 1) bus.start = 1'b0;
      if (disturb) begin
        if (k == 1) begin
          bus.op_a = 32'hAAAA_AAAA;
          bus.op_b = 32'h1111_1111;
        end
        bus.start = (k == 2);
      end
      busy_seen = busy_seen | bus.busy;
      overlap   = overlap | (bus.busy & bus.done);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ovf, input logic exp_inv,
                        input int exp_lat, input logic disturb);
    int   lat;
    logic bseen;
    logic ovl;
    launch(a, b);
    wait_done(1'b0, disturb, lat, bseen, ovl);
    chk({tag, " latency"},  lat,          exp_lat);
    chk({tag, " result"},   bus.result,   exp_res);
    chk({tag, " overflow"}, bus.overflow, {31'd0, exp_ovf});
    chk({tag, " invalid"},  bus.invalid,  {31'd0, exp_inv});
    chk({tag, " busy_seen"}, {31'd0, bseen}, {31'd0, !exp_inv});
    chk({tag, " busy_done_overlap"}, {31'd0, ovl}, 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " result_held"}, bus.result, exp_res);
  endtask

  initial begin
    int   lat;
    logic bseen;
    logic ovl;
    logic done_during_rst;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    repeat (2) @(negedge clk);
    chk("reset busy",     {31'd0, bus.busy},     32'd0);
    chk("reset done",     {31'd0, bus.done},     32'd0);
    chk("reset result",   bus.result,            32'd0);
    chk("reset overflow", {31'd0, bus.overflow}, 32'd0);
    chk("reset invalid",  {31'd0, bus.invalid},  32'd0);
    rst = 1'b0;

    run_op("basic",       32'h0000_1234, 32'h0000_5678, 32'h0000_6912, 1'b0, 1'b0, 5, 1'b0);
    run_op("ripple",      32'h9999_9999, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 5, 1'b0);
    run_op("max_nocarry", 32'h5050_5050, 32'h4949_4949, 32'h9999_9999, 1'b0, 1'b0, 5, 1'b0);
    run_op("max_sum",     32'h9999_9999, 32'h9999_9999, 32'h9999_9998, 1'b1, 1'b0, 5, 1'b0);
    run_op("invalid_lo",  32'h1234_5678, 32'h0000_000A, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b0);
    run_op("wrap_carry",  32'h4567_8901, 32'h5432_1099, 32'h0000_0000, 1'b1, 1'b0, 5, 1'b0);
    run_op("invalid_hi",  32'h0000_0000, 32'hF000_0000, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b0);
    run_op("disturb",     32'h0000_1234, 32'h0000_5678, 32'h0000_6912, 1'b0, 1'b0, 5, 1'b1);

    // start held high across a whole operation: re-accepted on the idle cycle after DONE
    launch(32'h0000_1234, 32'h0000_5678);
    wait_done(1'b1, 1'b0, lat, bseen, ovl);
    chk("held first latency", lat, 5);
    chk("held first result", bus.result, 32'h0000_6912);
    @(negedge clk);
    chk("held idle gap busy", {31'd0, bus.busy}, 32'd0);
    chk("held idle gap done", {31'd0, bus.done}, 32'd0);
    chk("held idle gap result", bus.result, 32'h0000_6912);
    bus.op_a = 32'h0000_0095;
    bus.op_b = 32'h0000_0005;
    @(posedge clk);
    wait_done(1'b0, 1'b0, lat, bseen, ovl);
    chk("held second latency", lat, 5);
    chk("held second result", bus.result, 32'h0000_0100);
    chk("held second overflow", {31'd0, bus.overflow}, 32'd0);

    // reset in the second ADD cycle aborts the operation
    launch(32'h0000_1234, 32'h0000_5678);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst busy", {31'd0, bus.busy}, 32'd1);
    chk("pre_rst partial result", bus.result, 32'h0000_0012);
    rst = 1'b1;
    #1;
    chk("rst busy",     {31'd0, bus.busy},     32'd0);
    chk("rst done",     {31'd0, bus.done},     32'd0);
    chk("rst result",   bus.result,            32'd0);
    chk("rst overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst invalid",  {31'd0, bus.invalid},  32'd0);
    done_during_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      done_during_rst = done_during_rst | bus.done;
      if (k == 2) rst = 1'b0;
    end
    chk("no done after abort", {31'd0, done_during_rst}, 32'd0);
    run_op("after_rst", 32'h9999_9999, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/bcd_add_sequencer.md
BCD_ADD_SEQUENCER -- requirements
Module: bcd_add_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PAIRS, default 4, giving the number of two-digit BCD pairs per operand; legal range 1..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to add op_a and op_b; sampled only in IDLE.
REQ-005 op_a  input  8*NUM_PAIRS  packed BCD operand A; least significant pair at [7:0].
REQ-006 op_b  input  8*NUM_PAIRS  packed BCD operand B; same packing.
REQ-007 busy  output  1  high in ADD state.
REQ-008 done  output  1  one-cycle pulse in DONE state.
REQ-009 result  output  8*NUM_PAIRS  packed BCD sum, registered.
REQ-010 overflow  output  1  decimal carry out of the most significant pair, registered.
REQ-011 invalid  output  1  an operand nibble exceeded 9 at capture, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-013 IDLE with start=1: op_a/op_b latched into internal registers; pair index=0; carry register=0; result, overflow and invalid cleared to 0.
REQ-014 Validity check at capture: if any nibble of op_a or op_b is >9, next state is DONE with invalid=1, result=0, overflow=0; otherwise next state is ADD.
REQ-015 ADD: one pair per cycle, least significant first, pair index 0..NUM_PAIRS-1; after the last pair, go to DONE.
REQ-016 Per-pair arithmetic:
- s1,c1 = two-digit BCD add of pair_a + pair_b.
- s2,c2 = two-digit BCD add of s1 + {7'b0, carry_reg}.
- Pair result = s2; carry_reg <= c1 | c2.
- Both adds are performed by instances of the team's two-digit BCD adder.
REQ-017 Pair sums span 0..199 and are always corrected into a valid BCD pair; carry_reg is always 0 or 1.
REQ-018 overflow SHALL equal carry_reg after the final pair.
REQ-019 DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency, start accepted at edge 0:
- Valid operands: done high in cycle NUM_PAIRS+1.
- Invalid operands: done high in cycle 1.
REQ-021 start is ignored in ADD and DONE; op_a/op_b changes after capture SHALL NOT affect the operation.
REQ-022 start held high continuously SHALL be accepted again on the first IDLE cycle after DONE, one idle cycle minimum between operations.
REQ-023 result, overflow and invalid SHALL hold their values from DONE until the next accepted start.
REQ-024 busy and done SHALL never be high in the same cycle.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE and zero all state: busy, done, result, overflow, invalid, carry_reg, pair index and operand registers.
REQ-026 rst asserted mid-ADD SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL operate normally.

Verification (NUM_PAIRS=4)
REQ-027 op_a=0x00001234, op_b=0x00005678, start pulse -> done in cycle 5, result=0x00006912, overflow=0, invalid=0.
REQ-028 0x99999999 + 0x00000001 -> result=0x00000000, overflow=1 (carry ripples through all pairs).
REQ-029 Boundary sums:
- 0x50505050 + 0x49494949 -> result=0x99999999, overflow=0.
- 0x99999999 + 0x99999999 -> result=0x99999998, overflow=1.
REQ-030 0x12345678 + 0x0000000A -> done in cycle 1, invalid=1, result=0, overflow=0, busy never asserted.
REQ-031 start pulsed again while busy, with operands changed -> ignored, original sum reported; start held high -> second operation begins the cycle after DONE.
REQ-032 rst asserted in cycle 2 of an ADD -> all outputs 0 immediately, no done pulse; the next start completes correctly.
